// File: rtl/fetch_pc_ctrl_if.sv
// Fetch-unit bus: instruction-memory request/response and decode handshake.
interface fetch_pc_ctrl_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    // Fetch controller side
    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, inst_ready
    );

    // Memory / decode side
    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, inst_ready
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Program-counter / fetch controller: one outstanding instruction fetch,
// redirect handling with stale-response discard, and a single-entry
// instruction holding register towards decode.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect,
    input  logic [31:0]     target,
    output logic            misalign,
    fetch_pc_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        discard_q, discard_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic        misalign_q, misalign_d;

    logic        redir_ok;
    logic        redir_bad;

    assign redir_ok  = redirect && (target[1:0] == 2'b00);
    assign redir_bad = redirect && (target[1:0] != 2'b00);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    state_d = (discard_q || redir_ok) ? S_FETCH : S_HOLD;
                end
            end
            S_HOLD: begin
                if (redir_ok || bus.inst_ready) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Output logic
    always_comb begin
        bus.imem_req   = (state_q == S_FETCH);
        bus.imem_addr  = pc_q;
        bus.inst_valid = (state_q == S_HOLD);
        bus.inst       = inst_q;
        bus.inst_pc    = inst_pc_q;
        misalign       = misalign_q;
    end

    // Datapath next values; a valid redirect overrides every other pc update
    always_comb begin
        pc_d          = pc_q;
        inflight_pc_d = inflight_pc_q;
        discard_d     = discard_q;
        inst_d        = inst_q;
        inst_pc_d     = inst_pc_q;
        misalign_d    = redir_bad;
        case (state_q)
            S_FETCH: begin
                if (bus.imem_ready) begin
                    inflight_pc_d = pc_q;
                    if (redir_ok) begin
                        discard_d = 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (bus.imem_rvalid) begin
                    if (discard_q || redir_ok) begin
                        discard_d = 1'b0;
                    end else begin
                        inst_d    = bus.imem_rdata;
                        inst_pc_d = inflight_pc_q;
                        pc_d      = inflight_pc_q + 32'd4;
                    end
                end else if (redir_ok) begin
                    discard_d = 1'b1;
                end
            end
            default: ;
        endcase
        if (redir_ok) begin
            pc_d = target;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q          <= RESET_PC;
            inflight_pc_q <= '0;
            discard_q     <= 1'b0;
            inst_q        <= NOP_INST;
            inst_pc_q     <= '0;
            misalign_q    <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            inflight_pc_q <= inflight_pc_d;
            discard_q     <= discard_d;
            inst_q        <= inst_d;
            inst_pc_q     <= inst_pc_d;
            misalign_q    <= misalign_d;
        end
    end

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_fetch_pc_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] target = '0;
    logic        misalign;
    logic        misalign_b;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    fetch_pc_ctrl_if bus_a ();
    fetch_pc_ctrl_if bus_b ();

    fetch_pc_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .redirect (redirect),
        .target   (target),
        .misalign (misalign),
        .bus      (bus_a)
    );

    // Second instance only to observe a non-zero reset PC
    fetch_pc_ctrl #(.RESET_PC(32'h8000_0000)) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .redirect (1'b0),
        .target   (32'h0),
        .misalign (misalign_b),
        .bus      (bus_b)
    );

    assign bus_b.imem_ready  = 1'b0;
    assign bus_b.imem_rvalid = 1'b0;
    assign bus_b.imem_rdata  = '0;
    assign bus_b.inst_ready  = 1'b0;

    always #5 clk = ~clk;

    // Reference model: fetching unless a request is outstanding or an
    // instruction is being held.
    logic [31:0] m_pc, m_infl, m_inst, m_ipc;
    logic        m_busy, m_hold, m_drop, m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc   = 32'h0000_0000;
        m_infl = '0;
        m_inst = 32'h0000_0013;
        m_ipc  = '0;
        m_busy = 1'b0;
        m_hold = 1'b0;
        m_drop = 1'b0;
        m_mis  = 1'b0;
    endtask

    task automatic model_edge(input logic r, input logic [31:0] t, input logic rdy,
                              input logic rv, input logic [31:0] rd, input logic ir);
        logic        ok;
        logic [31:0] npc;
        ok  = r && (t[1:0] == 2'b00);
        npc = m_pc;
        if (!m_busy && !m_hold) begin
            if (rdy) begin
                m_busy = 1'b1;
                m_infl = m_pc;
                if (ok) m_drop = 1'b1;
            end
        end else if (m_busy) begin
            if (rv) begin
                m_busy = 1'b0;
                if (m_drop || ok) begin
                    m_drop = 1'b0;
                end else begin
                    m_inst = rd;
                    m_ipc  = m_infl;
                    m_hold = 1'b1;
                    npc    = m_infl + 32'd4;
                end
            end else if (ok) begin
                m_drop = 1'b1;
            end
        end else begin
            if (ok || ir) m_hold = 1'b0;
        end
        m_pc  = ok ? t : npc;
        m_mis = r && (t[1:0] != 2'b00);
    endtask

    task automatic compare_all();
        logic exp_req;
        exp_req = !m_busy && !m_hold;
        check("imem_req", {31'b0, bus_a.imem_req}, {31'b0, exp_req});
        if (exp_req) check("imem_addr", bus_a.imem_addr, m_pc);
        check("inst_valid", {31'b0, bus_a.inst_valid}, {31'b0, m_hold});
        check("inst", bus_a.inst, m_inst);
        check("inst_pc", bus_a.inst_pc, m_ipc);
        check("misalign", {31'b0, misalign}, {31'b0, m_mis});
    endtask

    // Called at a negedge: apply inputs, clock once, update model, compare.
    task automatic step(input logic r, input logic [31:0] t, input logic rdy,
                        input logic rv, input logic [31:0] rd, input logic ir);
        redirect           = r;
        target             = t;
        bus_a.imem_ready   = rdy;
        bus_a.imem_rvalid  = rv;
        bus_a.imem_rdata   = rd;
        bus_a.inst_ready   = ir;
        @(posedge clk);
        model_edge(r, t, rdy, rv, rd, ir);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Asynchronous reset applied away from the clock edge
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        check("rst_inst_nop", bus_a.inst, 32'h0000_0013);
        check("rst_b_addr", bus_b.imem_addr, 32'h8000_0000);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        compare_all();
    endtask

    initial begin
        bus_a.imem_ready  = 1'b0;
        bus_a.imem_rvalid = 1'b0;
        bus_a.imem_rdata  = '0;
        bus_a.inst_ready  = 1'b0;
        @(negedge clk);
        do_reset();

        // Basic fetch from reset address
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        check("t033_req_low_wait", {31'b0, bus_a.imem_req}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093, 1'b0);
        check("t033_valid", {31'b0, bus_a.inst_valid}, 32'd1);
        check("t033_inst", bus_a.inst, 32'h0050_0093);
        check("t033_inst_pc", bus_a.inst_pc, 32'h0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t033_next_addr", bus_a.imem_addr, 32'h4);

        // Redirect while waiting drops the response
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0);
        check("t034_no_valid", {31'b0, bus_a.inst_valid}, 32'd0);
        check("t034_addr", bus_a.imem_addr, 32'h100);
        check("t034_inst_kept", bus_a.inst, 32'h0050_0093);

        // Misaligned redirect in HOLD, then a long stall in HOLD
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
        step(1'b1, 32'h102, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t035_mis", {31'b0, misalign}, 32'd1);
        check("t035_valid", {31'b0, bus_a.inst_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            idle();
            check("t036_inst_pc", bus_a.inst_pc, 32'h100);
        end
        check("t035_mis_gone", {31'b0, misalign}, 32'd0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t035_pc_kept", bus_a.imem_addr, 32'h104);

        // Address wrap at top of memory, redirect in FETCH without accept
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0, 1'b0);
        check("t037_redir_addr", bus_a.imem_addr, 32'hFFFF_FFFC);
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1);
        check("t037_wrap", bus_a.imem_addr, 32'h0);

        // Redirect in FETCH with accept: response discarded
        step(1'b1, 32'h200, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hBAD0_BAD0, 1'b0);
        check("redir_accept_drop", {31'b0, bus_a.inst_valid}, 32'd0);
        check("redir_accept_addr", bus_a.imem_addr, 32'h200);

        // Reset while waiting; a late response must be ignored
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();
        step(1'b0, 32'h0, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b0);
        check("t038_addr", bus_a.imem_addr, 32'h0);
        check("t038_no_valid", {31'b0, bus_a.inst_valid}, 32'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic        r, rdy, rv, ir;
            logic [31:0] t, rd;
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end
            r  = ($urandom_range(0, 7) == 0);
            t  = $urandom;
            if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
            if ($urandom_range(0, 15) == 0) t = 32'hFFFF_FFFC;
            rdy = $urandom_range(0, 1) == 1;
            rv  = $urandom_range(0, 1) == 1;
            rd  = $urandom;
            ir  = $urandom_range(0, 2) != 0;
            step(r, t, rdy, rv, rd, ir);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
